// File: rtl/div_seq_ctrl_if.sv
// Shared ALU op encoding and the EX/divider bundle seen by the divide sequencer.
package div_seq_pkg;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;
endpackage

interface div_seq_ctrl_if #(parameter int XLEN = 32);
  import div_seq_pkg::*;

  // EX stage side
  logic            ex_valid;
  alu_op_e         ex_op;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [4:0]      ex_tag;
  logic            ex_advance;
  logic            flush;
  logic            ex_stall;
  logic            res_valid;
  logic [XLEN-1:0] res_data;
  logic [4:0]      res_tag;
  // iterative divider side
  logic            div_start;
  logic            div_is_signed;
  logic            div_is_rem;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic [XLEN-1:0] div_result;
  logic            div_done;
  logic            div_busy;
  // status
  logic            timeout_err;

  // controller view
  modport slave (
    input  ex_valid, ex_op, ex_a, ex_b, ex_tag, ex_advance, flush,
           div_result, div_done, div_busy,
    output ex_stall, res_valid, res_data, res_tag,
           div_start, div_is_signed, div_is_rem, div_dividend, div_divisor,
           timeout_err
  );

  // pipeline + divider view
  modport master (
    output ex_valid, ex_op, ex_a, ex_b, ex_tag, ex_advance, flush,
           div_result, div_done, div_busy,
    input  ex_stall, res_valid, res_data, res_tag,
           div_start, div_is_signed, div_is_rem, div_dividend, div_divisor,
           timeout_err
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Divide sequencer for the EX stage: resolves divide-by-zero and signed
// overflow locally, otherwise issues one start to the iterative divider,
// stalls EX until the result is ready and holds it until EX advances.
module div_seq_ctrl
  import div_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  div_seq_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int              WDW     = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [XLEN-1:0] res_data_q, res_data_d;
  logic [4:0]      res_tag_q, res_tag_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic            sgn_q, sgn_d;
  logic            rem_q, rem_d;
  logic            timeout_q, timeout_d;

  logic is_div, op_sgn, op_rem;
  logic div_zero, sgn_ovf, wd_fire;
  logic start;

  // Decode the EX op and the two cases that never need the divider
  always_comb begin
    is_div   = (bus.ex_op == ALU_DIV) || (bus.ex_op == ALU_DIVU) ||
               (bus.ex_op == ALU_REM) || (bus.ex_op == ALU_REMU);
    op_sgn   = (bus.ex_op == ALU_DIV) || (bus.ex_op == ALU_REM);
    op_rem   = (bus.ex_op == ALU_REM) || (bus.ex_op == ALU_REMU);
    div_zero = (bus.ex_b == '0);
    sgn_ovf  = op_sgn && (bus.ex_a == INT_MIN) && (bus.ex_b == '1);
    wd_fire  = (wd_q == WD_LAST);
  end

  // Next-state, result capture, operand latch and watchdog
  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    res_data_d = res_data_q;
    res_tag_d  = res_tag_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sgn_d      = sgn_q;
    rem_d      = rem_q;
    timeout_d  = timeout_q;
    start      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ex_valid && is_div && !bus.flush) begin
          if (div_zero) begin
            // x/0 = all ones, x%0 = x
            res_data_d = op_rem ? bus.ex_a : '1;
            res_tag_d  = bus.ex_tag;
            state_d    = S_DONE;
          end else if (sgn_ovf) begin
            // MIN/-1 = MIN, MIN%-1 = 0
            res_data_d = op_rem ? '0 : INT_MIN;
            res_tag_d  = bus.ex_tag;
            state_d    = S_DONE;
          end else if (!bus.div_busy) begin
            start      = 1'b1;
            dividend_d = bus.ex_a;
            divisor_d  = bus.ex_b;
            sgn_d      = op_sgn;
            rem_d      = op_rem;
            res_tag_d  = bus.ex_tag;
            wd_d       = '0;
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          // a done arriving with the flush is simply dropped; nothing left to drain
          state_d = bus.div_done ? S_IDLE : S_DRAIN;
          wd_d    = '0;
        end else if (bus.div_done) begin
          res_data_d = bus.div_result;
          state_d    = S_DONE;
        end else if (wd_fire) begin
          res_data_d = '0;
          timeout_d  = 1'b1;
          state_d    = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (bus.div_done) begin
          state_d = S_IDLE;
        end else if (wd_fire) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        // S_DONE: either EX takes the result or the instruction is killed
        if (bus.flush || bus.ex_advance) state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wd_q       <= '0;
      res_data_q <= '0;
      res_tag_q  <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      sgn_q      <= 1'b0;
      rem_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      res_data_q <= res_data_d;
      res_tag_q  <= res_tag_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sgn_q      <= sgn_d;
      rem_q      <= rem_d;
      timeout_q  <= timeout_d;
    end
  end

  // Outputs; operands pass straight through in the start cycle so the
  // divider sees them before the registers load
  always_comb begin
    bus.div_start     = start && !reset;
    bus.div_dividend  = bus.div_start ? bus.ex_a : dividend_q;
    bus.div_divisor   = bus.div_start ? bus.ex_b : divisor_q;
    bus.div_is_signed = bus.div_start ? op_sgn   : sgn_q;
    bus.div_is_rem    = bus.div_start ? op_rem   : rem_q;
    bus.ex_stall      = bus.ex_valid && is_div && (state_q != S_DONE) && !bus.flush;
    bus.res_valid     = (state_q == S_DONE);
    bus.res_data      = res_data_q;
    bus.res_tag       = res_tag_q;
    bus.timeout_err   = timeout_q;
  end

endmodule
